// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : alu_pkg
// Purpose: Shared definitions for the 32-bit ALU and the mod sequencer:
//          3-bit alu_ctr operation codes and the sequencer state encoding.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MOD = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CMP   = 3'd2,
    SUB   = 3'd3,
    FIN   = 3'd4,
    ERR   = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mod_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : alu_mod_sequencer_if
// Purpose: Bundles the request/response handshake and the shared-ALU bus of
//          the mod sequencer.
//   master : datapath side (drives start/operands, returns ALU result)
//   slave  : sequencer side
// Signals: start, dividend, divisor, busy, done, err, mod_result,
//          alu_own, alu_src1, alu_src2, alu_ctr, alu_result, zero_bit
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface alu_mod_sequencer_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mod_result;
  logic        alu_own;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_result;
  logic        zero_bit;

  modport master (
    output start, dividend, divisor, alu_result, zero_bit,
    input  busy, done, err, mod_result, alu_own, alu_src1, alu_src2, alu_ctr
  );

  modport slave (
    input  start, dividend, divisor, alu_result, zero_bit,
    output busy, done, err, mod_result, alu_own, alu_src1, alu_src2, alu_ctr
  );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : alu
// Purpose: Combinational 32-bit ALU shared with the mod sequencer. The mod
//          slot (ALU_MOD) returns 0 here; the datapath routes it to the
//          sequencer instead.
// Ports  : i_src1, i_src2 (32) operands; i_ctr (3) operation;
//          o_result (32); o_zero = (i_src1 == i_src2)
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  wire logic [31:0] i_src1,
  input  wire logic [31:0] i_src2,
  input  wire logic [2:0]  i_ctr,
  output logic      [31:0] o_result,
  output logic             o_zero
);

  always_comb begin
    o_result = '0;
    case (i_ctr)
      ALU_AND: o_result = i_src1 & i_src2;
      ALU_OR:  o_result = i_src1 | i_src2;
      ALU_XOR: o_result = i_src1 ^ i_src2;
      ALU_ADD: o_result = i_src1 + i_src2;
      ALU_SLT: o_result = {31'd0, ($signed(i_src1) < $signed(i_src2))};
      ALU_NOR: o_result = ~(i_src1 | i_src2);
      ALU_SUB: o_result = i_src1 - i_src2;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (i_src1 == i_src2);

endmodule
`default_nettype wire

// File: rtl/mod_iter_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mod_iter_counter
// Purpose: Subtraction counter for the mod sequencer with terminal compare.
// Ports  : clk, rst_n (async active-low); i_clear, i_inc;
//          o_count (32); o_at_max = (count == MAX_ITER)
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module mod_iter_counter #(
  parameter logic [31:0] MAX_ITER = 32'd65535
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_clear,
  input  wire logic        i_inc,
  output logic      [31:0] o_count,
  output logic             o_at_max
);

  logic [31:0] r_count;

  // The sequencer checks o_at_max before every increment, so no wrap guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc)   r_count <= r_count + 32'd1;
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == MAX_ITER);

endmodule
`default_nettype wire

// File: rtl/alu_mod_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : alu_mod_sequencer
// Purpose: Multi-cycle A mod B on the shared ALU by repeated SLT/SUB.
//          While busy it owns the ALU (alu_own=1).
// Ports  : CLK, reset (async active-low); bus (alu_mod_sequencer_if.slave);
//          quotient (32, only with ALU_MOD_QUOTIENT_EN)
// Config : ALU_MOD_QUOTIENT_EN adds the registered quotient output.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module alu_mod_sequencer
  import alu_pkg::*;
#(
  parameter logic [31:0] MAX_ITER = 32'd65535
) (
  input  wire logic   CLK,
  input  wire logic   reset,
`ifdef ALU_MOD_QUOTIENT_EN
  output logic [31:0] quotient,
`endif
  alu_mod_sequencer_if.slave bus
);

  seq_state_t  r_state;
  seq_state_t  w_next;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_mod;
  logic [31:0] w_iter;
  logic        w_at_max;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && bus.start;

  mod_iter_counter #(.MAX_ITER(MAX_ITER)) u_iter (
    .clk      (CLK),
    .rst_n    (reset),
    .i_clear  (w_accept),
    .i_inc    (r_state == SUB),
    .o_count  (w_iter),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // done/err are registered from FIN/ERR, so they appear in the IDLE cycle
  // that follows; a start in that cycle is accepted.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_mod  <= '0;
    end else begin
      r_done <= (r_state == FIN) || (r_state == ERR);
      r_err  <= (r_state == ERR);
      if (w_accept) begin
        r_rem <= bus.dividend;
        r_div <= bus.divisor;
      end else if (r_state == SUB) begin
        r_rem <= bus.alu_result;
      end
      if (r_state == FIN)      r_mod <= r_rem;
      else if (r_state == ERR) r_mod <= '0;
    end
  end

`ifdef ALU_MOD_QUOTIENT_EN
  logic [31:0] r_quo;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)              r_quo <= '0;
    else if (r_state == FIN) r_quo <= w_iter;
    else if (r_state == ERR) r_quo <= '0;
  end
  assign quotient = r_quo;
`else
  logic w_unused_iter;
  assign w_unused_iter = ^w_iter;
`endif

  always_comb begin
    w_next       = r_state;
    bus.alu_own  = 1'b0;
    bus.alu_src1 = '0;
    bus.alu_src2 = '0;
    bus.alu_ctr  = ALU_AND;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = CHECK;
      end
      CHECK: begin
        // XOR against 0 makes zero_bit flag a zero divisor.
        bus.alu_own  = 1'b1;
        bus.alu_ctr  = ALU_XOR;
        bus.alu_src1 = r_div;
        if (bus.zero_bit || r_rem[31] || r_div[31]) w_next = ERR;
        else                                        w_next = CMP;
      end
      CMP: begin
        bus.alu_own  = 1'b1;
        bus.alu_ctr  = ALU_SLT;
        bus.alu_src1 = r_rem;
        bus.alu_src2 = r_div;
        if (bus.alu_result[0]) w_next = FIN;
        else if (w_at_max)     w_next = ERR;
        else                   w_next = SUB;
      end
      SUB: begin
        bus.alu_own  = 1'b1;
        bus.alu_ctr  = ALU_SUB;
        bus.alu_src1 = r_rem;
        bus.alu_src2 = r_div;
        w_next       = CMP;
      end
      FIN:     w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.mod_result = r_mod;

endmodule
`default_nettype wire
